// File: rtl/memory_writer.sv
// -----------------------------------------------------------------------------
// memory_writer
//
// Purpose:
//   Accepts one store request at a time and writes it into a byte-wide RAM
//   port, least-significant byte first. A store is 1, 2 or 4 bytes long. An
//   illegal length is accepted, performs no RAM access, and is reported with
//   err alongside done. The RAM may stall. A global enable freezes the block.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   global enable; 0 freezes all state and blanks ram_en
//   req_valid  in   store request presented
//   len_in     in   [2:0] size code: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes
//   addr_in    in   [31:0] store byte address (low ADDR_WIDTH bits used)
//   data_in    in   [31:0] store data, LSB first
//   ready      out  a request can be accepted this cycle
//   done       out  one-cycle completion pulse
//   err        out  one-cycle pulse with done for an illegal length
//   ram_stall  in   RAM cannot take a byte this cycle
//   ram_en     out  RAM access strobe
//   ram_rw_en  out  RAM direction (1 = read, 0 = write); always write
//   addr_out   out  [ADDR_WIDTH-1:0] RAM byte address
//   data_out   out  [7:0] RAM write byte
// -----------------------------------------------------------------------------
module memory_writer #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  req_valid,
    input  logic [2:0]            len_in,
    input  logic [31:0]           addr_in,
    input  logic [31:0]           data_in,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    input  logic                  ram_stall,
    output logic                  ram_en,
    output logic                  ram_rw_en,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [7:0]            data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_q;
    logic [1:0]            k_q;        // index of the byte currently on the RAM port
    logic [1:0]            last_q;     // index of the final byte (N-1)
    logic [23:0]           rest_q;     // bytes not yet presented, next one in [7:0]
    logic                  ready_q;
    logic                  done_q;
    logic                  err_q;
    logic                  ram_en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            dout_q;
    logic [2:0]            len_dec_s;
    logic [ADDR_WIDTH-1:0] addr_inc_d;

    // Decode the size code into {legal, index of last byte}.
    function automatic logic [2:0] decode_len(input logic [2:0] len);
        logic [2:0] r;
        case (len)
            3'd0:    r = {1'b1, 2'd0};
            3'd1:    r = {1'b1, 2'd1};
            3'd2:    r = {1'b1, 2'd3};
            default: r = {1'b0, 2'd0};
        endcase
        return r;
    endfunction

    // Size decode and next byte address; the add wraps at 2^ADDR_WIDTH.
    always_comb begin
        len_dec_s  = decode_len(len_in);
        addr_inc_d = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end

    // Control FSM with registered outputs; nothing moves while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= 2'd0;
            last_q   <= 2'd0;
            rest_q   <= 24'd0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ram_en_q <= 1'b0;
            addr_q   <= {ADDR_WIDTH{1'b0}};
            dout_q   <= 8'd0;
        end else if (en) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                // ready is high in both states, so a request is taken directly.
                IDLE, DONE: begin
                    if (req_valid) begin
                        if (len_dec_s[2]) begin
                            state_q  <= WRITE;
                            ready_q  <= 1'b0;
                            ram_en_q <= 1'b1;
                            k_q      <= 2'd0;
                            last_q   <= len_dec_s[1:0];
                            addr_q   <= addr_in[ADDR_WIDTH-1:0];
                            dout_q   <= data_in[7:0];
                            rest_q   <= data_in[31:8];
                        end else begin
                            state_q  <= DONE;
                            ready_q  <= 1'b1;
                            ram_en_q <= 1'b0;
                            done_q   <= 1'b1;
                            err_q    <= 1'b1;
                        end
                    end else begin
                        state_q  <= IDLE;
                        ready_q  <= 1'b1;
                        ram_en_q <= 1'b0;
                    end
                end
                // A byte counts as written only in a cycle without stall.
                WRITE: begin
                    if (!ram_stall) begin
                        if (k_q == last_q) begin
                            state_q  <= DONE;
                            ready_q  <= 1'b1;
                            ram_en_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            k_q    <= k_q + 2'd1;
                            addr_q <= addr_inc_d;
                            dout_q <= rest_q[7:0];
                            rest_q <= {8'd0, rest_q[23:8]};
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    ready_q  <= 1'b1;
                    ram_en_q <= 1'b0;
                    k_q      <= 2'd0;
                end
            endcase
        end
    end

    // The strobe is gated in the same cycle by stall and enable.
    assign ram_en    = ram_en_q & en & ~ram_stall;
    assign ram_rw_en = 1'b0;
    assign ready     = ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign addr_out  = addr_q;
    assign data_out  = dout_q;

    // Address bits above the RAM width are deliberately ignored.
    generate
        if (ADDR_WIDTH < 32) begin : g_unused_addr
            logic unused_addr_s;
            assign unused_addr_s = ^addr_in[31:ADDR_WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_memory_writer.sv
module tb_memory_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        req_valid;
    logic [2:0]  len_in;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic        ready;
    logic        done;
    logic        err;
    logic        ram_stall;
    logic        ram_en;
    logic        ram_rw_en;
    logic [16:0] addr_out;
    logic [7:0]  data_out;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    memory_writer #(.ADDR_WIDTH(17)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .len_in    (len_in),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .ram_stall (ram_stall),
        .ram_en    (ram_en),
        .ram_rw_en (ram_rw_en),
        .addr_out  (addr_out),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] len, input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        len_in    = len;
        addr_in   = addr;
        data_in   = data;
    endtask

    // Drop the request and scramble the inputs so latching is exercised.
    task automatic unreq();
        req_valid = 1'b0;
        len_in    = 3'd7;
        addr_in   = 32'hDEAD_BEEF;
        data_in   = 32'hCAFE_F00D;
    endtask

    task automatic exp_write(input string tag, input logic [16:0] a, input logic [7:0] d);
        chk({tag, "_en"},   {31'd0, ram_en},    32'd1);
        chk({tag, "_rw"},   {31'd0, ram_rw_en}, 32'd0);
        chk({tag, "_addr"}, {15'd0, addr_out},  {15'd0, a});
        chk({tag, "_data"}, {24'd0, data_out},  {24'd0, d});
        chk({tag, "_rdy"},  {31'd0, ready},     32'd0);
        chk({tag, "_done"}, {31'd0, done},      32'd0);
    endtask

    task automatic exp_done(input string tag, input logic e);
        chk({tag, "_done"}, {31'd0, done},   32'd1);
        chk({tag, "_err"},  {31'd0, err},    {31'd0, e});
        chk({tag, "_rdy"},  {31'd0, ready},  32'd1);
        chk({tag, "_en"},   {31'd0, ram_en}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; ram_stall = 1'b0;
        req_valid = 1'b0; len_in = 3'd0; addr_in = 32'd0; data_in = 32'd0;
        #2;
        chk("rst_ready", {31'd0, ready},    32'd1);
        chk("rst_done",  {31'd0, done},     32'd0);
        chk("rst_err",   {31'd0, err},      32'd0);
        chk("rst_ram_en",{31'd0, ram_en},   32'd0);
        chk("rst_rw",    {31'd0, ram_rw_en},32'd0);
        chk("rst_addr",  {15'd0, addr_out}, 32'd0);
        chk("rst_data",  {24'd0, data_out}, 32'd0);
        #20;
        rst = 1'b0;

        // Word store, accepted on the first edge after reset release.
        req(3'd2, 32'h0000_0100, 32'h1122_3344);
        step(); unreq();
        exp_write("w0", 17'h00100, 8'h44);
        step(); exp_write("w1", 17'h00101, 8'h33);
        step(); exp_write("w2", 17'h00102, 8'h22);
        step(); exp_write("w3", 17'h00103, 8'h11);
        step(); exp_done("w_done", 1'b0);
        step();
        chk("w_idle_done", {31'd0, done},  32'd0);
        chk("w_idle_rdy",  {31'd0, ready}, 32'd1);

        // Halfword store wrapping at the top of the address space.
        req(3'd1, 32'h0001_FFFF, 32'h0000_ABCD);
        step(); unreq();
        exp_write("h0", 17'h1FFFF, 8'hCD);
        step(); exp_write("h1", 17'h00000, 8'hAB);
        step(); exp_done("h_done", 1'b0);
        step();

        // Byte store with stall in T+1..T+2.
        req(3'd0, 32'h0000_0010, 32'h0000_005A);
        step(); unreq(); ram_stall = 1'b1; #1;
        chk("s1_en",   {31'd0, ram_en},    32'd0);
        chk("s1_addr", {15'd0, addr_out},  32'h10);
        step();
        chk("s2_en",   {31'd0, ram_en},    32'd0);
        chk("s2_rdy",  {31'd0, ready},     32'd0);
        chk("s2_done", {31'd0, done},      32'd0);
        step(); ram_stall = 1'b0; #1;
        exp_write("s3", 17'h00010, 8'h5A);
        step(); exp_done("s_done", 1'b0);
        step();

        // Illegal length: immediate done with err, no RAM access.
        req(3'd3, 32'h0000_0030, 32'h0000_00FF);
        step(); unreq();
        exp_done("ill", 1'b1);
        step();
        chk("ill_after_done", {31'd0, done}, 32'd0);
        chk("ill_after_err",  {31'd0, err},  32'd0);

        // Back-to-back byte stores, the second taken on the done cycle.
        req(3'd0, 32'h0000_0020, 32'h0000_0077);
        step(); unreq();
        exp_write("bb1", 17'h00020, 8'h77);
        step(); exp_done("bb1_done", 1'b0);
        req(3'd0, 32'h0000_0021, 32'h0000_0088);
        step(); unreq();
        exp_write("bb2", 17'h00021, 8'h88);
        step(); exp_done("bb2_done", 1'b0);
        step();

        // Enable low mid-store freezes everything and counts nothing.
        req(3'd1, 32'h0000_0040, 32'h0000_1234);
        step(); unreq();
        exp_write("e0", 17'h00040, 8'h34);
        en = 1'b0; #1;
        chk("e_off_en", {31'd0, ram_en}, 32'd0);
        step();
        chk("e_off_en2",  {31'd0, ram_en},   32'd0);
        chk("e_off_addr", {15'd0, addr_out}, 32'h40);
        chk("e_off_rdy",  {31'd0, ready},    32'd0);
        en = 1'b1; #1;
        exp_write("e0_again", 17'h00040, 8'h34);
        step(); exp_write("e1", 17'h00041, 8'h12);
        step(); exp_done("e_done", 1'b0);
        step();

        // Reset during byte 2 of a word store.
        req(3'd2, 32'h0000_0200, 32'hA1B2_C3D4);
        step(); unreq();
        exp_write("r0", 17'h00200, 8'hD4);
        step(); exp_write("r1", 17'h00201, 8'hC3);
        step(); exp_write("r2", 17'h00202, 8'hB2);
        #2; rst = 1'b1; #1;
        chk("r_rst_en",   {31'd0, ram_en}, 32'd0);
        chk("r_rst_rdy",  {31'd0, ready},  32'd1);
        chk("r_rst_done", {31'd0, done},   32'd0);
        step();
        chk("r_rst_en2",   {31'd0, ram_en}, 32'd0);
        chk("r_rst_done2", {31'd0, done},   32'd0);
        rst = 1'b0;
        req(3'd0, 32'h0000_0005, 32'h0000_003C);
        step(); unreq();
        exp_write("r_new", 17'h00005, 8'h3C);
        step(); exp_done("r_new_done", 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/memory_writer.md
MEMORY_WRITER -- requirements
Module: memory_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17, the RAM byte-address width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port en, input, 1, global enable; when 0, all state and outputs freeze and ram_en is forced to 0.
REQ-005 SHALL have port req_valid, input, 1, a store request is presented.
REQ-006 SHALL have port len_in, input, 3, store size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, other values illegal.
REQ-007 SHALL have port addr_in, input, 32, store byte address.
REQ-008 SHALL have port data_in, input, 32, store data, least-significant byte first.
REQ-009 SHALL have port ready, output, 1, the block can accept a request this cycle.
REQ-010 SHALL have port done, output, 1, one-cycle pulse marking completion of the accepted request.
REQ-011 SHALL have port err, output, 1, one-cycle pulse coincident with done for an illegal len_in.
REQ-012 SHALL have port ram_stall, input, 1, the RAM side cannot take a byte this cycle.
REQ-013 SHALL have port ram_en, output, 1, RAM access strobe.
REQ-014 SHALL have port ram_rw_en, output, 1, RAM direction: 1 = read, 0 = write.
REQ-015 SHALL have port addr_out, output, ADDR_WIDTH, RAM byte address.
REQ-016 SHALL have port data_out, output, 8, RAM write byte.

Function
REQ-017 SHALL accept a request in cycle T when req_valid=1, ready=1 and en=1, latching addr_in[ADDR_WIDTH-1:0], data_in and len_in, and dropping ready in T+1.
REQ-018 SHALL have states IDLE, WRITE and DONE; IDLE->WRITE on a legal accept; IDLE->DONE on an illegal accept; WRITE->DONE after the last byte is issued; DONE->IDLE, or DONE->WRITE/DONE on a same-cycle accept.
REQ-019 SHALL, in WRITE, drive ram_en=1, ram_rw_en=0, addr_out=base+k and data_out=data[8k+7:8k] for byte index k=0..N-1, with N=1, 2 or 4 from len_in.
REQ-020 SHALL issue byte 0 in T+1 and one byte per cycle after that while ram_stall=0.
REQ-021 SHALL, in any WRITE cycle with ram_stall=1, drive ram_en=0 and hold k, addr_out and data_out; the byte is re-issued in the first cycle with ram_stall=0.
REQ-022 SHALL compute addr_out as base+k modulo 2^ADDR_WIDTH; an access starting at the top address wraps to 0.
REQ-023 SHALL, in DONE, assert done=1 and ready=1 for exactly one cycle with ram_en=0; with no stalls, done is asserted in cycle T+N+1.
REQ-024 SHALL accept a new request in the DONE cycle; its byte 0 then appears in the following cycle, with no idle gap.
REQ-025 SHALL hold ready=1 in IDLE and ready=0 in WRITE.
REQ-026 SHALL treat an illegal len_in as accepted, issue no RAM access, and pulse done=1 and err=1 in T+1.
REQ-027 SHALL drive ram_rw_en=0 at all times, since the block only writes.
REQ-028 SHALL ignore req_valid while ready=0; inputs need not be held after acceptance.
REQ-029 SHALL hold all state while en=0 and resume exactly where it stopped when en returns to 1, counting no byte during the en=0 cycles.

Reset
REQ-030 SHALL, on rst=1 and regardless of clk, force state=IDLE, ready=1, done=0, err=0, ram_en=0, ram_rw_en=0, addr_out=0, data_out=0 and k=0.
REQ-031 SHALL, on reset mid-request, abandon the request with no done pulse; no further RAM byte is written after rst rises.
REQ-032 SHALL allow acceptance in the first rising edge after rst falls.

Verification
REQ-033 SHALL pass: word store, addr 0x00000100, data 0x11223344, len 2, no stall -> writes 0x44@0x100, 0x33@0x101, 0x22@0x102, 0x11@0x103 in T+1..T+4; done at T+5.
REQ-034 SHALL pass: halfword store to 0x1FFFF, data 0x0000ABCD, len 1 -> 0xCD@0x1FFFF then 0xAB@0x00000; done at T+3.
REQ-035 SHALL pass: byte store 0x5A@0x10 with ram_stall=1 during T+1..T+2 -> ram_en=0 in those cycles; 0x5A@0x10 in T+3; done at T+4.
REQ-036 SHALL pass: len 3 request -> no ram_en; done=1 and err=1 in T+1; ready=1.
REQ-037 SHALL pass: two back-to-back byte stores, the second accepted on the done cycle -> byte writes at T+1 and T+3, done at T+2 and T+4.
REQ-038 SHALL pass: rst asserted during byte 2 of a word store -> ram_en=0 immediately, ready=1, no done; a new request is accepted on the next edge after rst falls.
